// File: rtl/branch_target_table_if.sv
// Bus bundle for branch_target_table: bank control, entry load, clear, lookup and debug.
// Lookup handshake: rd_req is taken on every edge (no back-pressure); rd_valid/hit/Target answer it for exactly one cycle.
interface branch_target_table_if #(
  parameter int ADDR_W = 5,
  parameter int TGT_W  = 10,
  parameter int BANKS  = 4
);
  localparam int BANK_W = $clog2(BANKS);

  logic [BANK_W-1:0] bank_sel;
  logic              bank_switch;
  logic              wr_en;
  logic [BANK_W-1:0] wr_bank;
  logic [ADDR_W-1:0] wr_addr;
  logic [TGT_W-1:0]  wr_data;
  logic              clr_req;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [TGT_W-1:0]  Target;
  logic              hit;
  logic              busy;
  logic              wr_drop;
  logic              dbg_state;
  logic [ADDR_W-1:0] dbg_clr_idx;
  logic [BANK_W-1:0] dbg_active_bank;

  modport master (
    output bank_sel, bank_switch, wr_en, wr_bank, wr_addr, wr_data,
    output clr_req, rd_req, rd_addr,
    input  rd_valid, Target, hit, busy, wr_drop,
    input  dbg_state, dbg_clr_idx, dbg_active_bank
  );

  modport slave (
    input  bank_sel, bank_switch, wr_en, wr_bank, wr_addr, wr_data,
    input  clr_req, rd_req, rd_addr,
    output rd_valid, Target, hit, busy, wr_drop,
    output dbg_state, dbg_clr_idx, dbg_active_bank
  );
endinterface

// File: rtl/branch_target_table.sv
// Banked branch target table: BANKS x 2**ADDR_W targets with valid bits, one-cycle lookup
// from the active bank, write-through bypass and a one-index-per-cycle clear sequencer.
module branch_target_table #(
  parameter int ADDR_W = 5,
  parameter int TGT_W  = 10,
  parameter int BANKS  = 4
) (
  input logic              Clk,
  input logic              Reset_n,
  branch_target_table_if.slave bus
);
  localparam int BANK_W = $clog2(BANKS);
  localparam int DEPTH  = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic [BANK_W-1:0] active_bank_q, active_bank_d;
  logic [BANKS-1:0][DEPTH-1:0] vld_q, vld_d;
  logic [TGT_W-1:0]  mem_q [BANKS][DEPTH];

  logic              rd_valid_q, rd_valid_d;
  logic              hit_q, hit_d;
  logic [TGT_W-1:0]  target_q, target_d;
  logic              wr_drop_q, wr_drop_d;

  logic              busy;
  logic              wr_ok;

  // FSM: state register
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= S_IDLE;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // FSM: next state; clr_req is only looked at from IDLE, so a clear never restarts
  always_comb begin
    state_d   = state_q;
    clr_idx_d = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.clr_req) state_d = S_CLEAR;
      end
      S_CLEAR: begin
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == LAST_IDX) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == S_CLEAR);
  end

  // A write that coincides with a clear request is dropped along with writes during CLEAR.
  assign wr_ok     = bus.wr_en & ~busy & ~bus.clr_req;
  assign wr_drop_d = bus.wr_en & (busy | bus.clr_req);

  always_comb begin
    active_bank_d = active_bank_q;
    if (bus.bank_switch) active_bank_d = bus.bank_sel;
  end

  always_comb begin
    vld_d = vld_q;
    if (busy) begin
      for (int b = 0; b < BANKS; b++) vld_d[b][clr_idx_q] = 1'b0;
    end else if (wr_ok) begin
      vld_d[bus.wr_bank][bus.wr_addr] = 1'b1;
    end
  end

  // Lookup uses the pre-edge active bank; a same-edge write to that entry is forwarded.
  always_comb begin
    rd_valid_d = bus.rd_req;
    hit_d      = 1'b0;
    target_d   = '0;
    if (bus.rd_req && !busy) begin
      if (wr_ok && bus.wr_bank == active_bank_q && bus.wr_addr == bus.rd_addr) begin
        hit_d    = 1'b1;
        target_d = bus.wr_data;
      end else if (vld_q[active_bank_q][bus.rd_addr]) begin
        hit_d    = 1'b1;
        target_d = mem_q[active_bank_q][bus.rd_addr];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      active_bank_q <= '0;
      vld_q         <= '0;
      rd_valid_q    <= 1'b0;
      hit_q         <= 1'b0;
      target_q      <= '0;
      wr_drop_q     <= 1'b0;
    end else begin
      active_bank_q <= active_bank_d;
      vld_q         <= vld_d;
      rd_valid_q    <= rd_valid_d;
      hit_q         <= hit_d;
      target_q      <= target_d;
      wr_drop_q     <= wr_drop_d;
    end
  end

  // Target storage is deliberately not reset or cleared; the valid bits gate every read.
  always_ff @(posedge Clk) begin
    if (wr_ok) mem_q[bus.wr_bank][bus.wr_addr] <= bus.wr_data;
  end

  assign bus.rd_valid        = rd_valid_q;
  assign bus.hit             = hit_q;
  assign bus.Target          = target_q;
  assign bus.busy            = busy;
  assign bus.wr_drop         = wr_drop_q;
  assign bus.dbg_state       = state_q;
  assign bus.dbg_clr_idx     = clr_idx_q;
  assign bus.dbg_active_bank = active_bank_q;
endmodule

// File: tb/tb_branch_target_table.sv
// Bench for branch_target_table: directed scenarios plus random traffic against a table model,
// and a small second instance with ADDR_W=3, TGT_W=16, BANKS=2.
module tb_branch_target_table;
  localparam int DEPTH = 32;

  logic Clk;
  logic Reset_n;

  int total = 0;
  int bad   = 0;

  branch_target_table_if #(.ADDR_W(5), .TGT_W(10), .BANKS(4)) bif ();
  branch_target_table_if #(.ADDR_W(3), .TGT_W(16), .BANKS(2)) bif2 ();

  branch_target_table #(.ADDR_W(5), .TGT_W(10), .BANKS(4)) u_dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bif)
  );
  branch_target_table #(.ADDR_W(3), .TGT_W(16), .BANKS(2)) u_dut2 (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bif2)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  logic [9:0]  mem_m [4][DEPTH];
  bit          vld_m [4][DEPTH];
  int          active_m;
  int          busy_cnt;
  logic [10:0] exp_q[$];

  task automatic model_reset();
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < DEPTH; a++) vld_m[b][a] = 1'b0;
    active_m = 0;
    busy_cnt = 0;
    exp_q.delete();
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic set_idle();
    bif.bank_sel = '0; bif.bank_switch = 1'b0; bif.wr_en = 1'b0; bif.wr_bank = '0;
    bif.wr_addr = '0; bif.wr_data = '0; bif.clr_req = 1'b0; bif.rd_req = 1'b0; bif.rd_addr = '0;
  endtask

  // One clock cycle: drive, predict, clock, compare.
  task automatic step(input bit we, input int wb, input int wa, input int wd,
                      input bit rq, input int ra, input bit sw, input int bs, input bit cr);
    logic [10:0] e;
    bit wr_ok, exp_drop;
    @(negedge Clk);
    bif.wr_en = we; bif.wr_bank = 2'(wb); bif.wr_addr = 5'(wa); bif.wr_data = 10'(wd);
    bif.rd_req = rq; bif.rd_addr = 5'(ra);
    bif.bank_switch = sw; bif.bank_sel = 2'(bs); bif.clr_req = cr;
    wr_ok    = we && busy_cnt == 0 && !cr;
    exp_drop = we && !wr_ok;
    if (rq) begin
      if (busy_cnt > 0) e = '0;
      else if (wr_ok && wb == active_m && wa == ra) e = {1'b1, 10'(wd)};
      else if (vld_m[active_m][ra]) e = {1'b1, mem_m[active_m][ra]};
      else e = '0;
      exp_q.push_back(e);
    end
    if (wr_ok) begin
      mem_m[wb][wa] = 10'(wd);
      vld_m[wb][wa] = 1'b1;
    end
    if (busy_cnt > 0) busy_cnt--;
    else if (cr) begin
      busy_cnt = DEPTH;
      for (int b = 0; b < 4; b++)
        for (int a = 0; a < DEPTH; a++) vld_m[b][a] = 1'b0;
    end
    if (sw) active_m = bs;
    @(posedge Clk);
    #1;
    chk("rd_valid", bif.rd_valid, rq);
    if (rq && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("hit", bif.hit, e[10]);
      chk("target", bif.Target, e[9:0]);
    end else begin
      chk("hit_idle", bif.hit, 0);
      chk("target_idle", bif.Target, 0);
    end
    chk("busy", bif.busy, busy_cnt > 0);
    chk("wr_drop", bif.wr_drop, exp_drop);
    chk("active_bank", bif.dbg_active_bank, active_m);
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic read_step(input int ra);
    step(0, 0, 0, 0, 1, ra, 0, 0, 0);
  endtask

  task automatic check_all_invalid(input string tag);
    for (int b = 0; b < 4; b++) begin
      step(0, 0, 0, 0, 0, 0, 1, b, 0);
      for (int a = 0; a < DEPTH; a++) begin
        read_step(a);
        chk(tag, bif.hit, 0);
      end
    end
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic reset_now();
    set_idle();
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    chk("rst_busy", bif.busy, 0);
    chk("rst_active", bif.dbg_active_bank, 0);
    chk("rst_state", bif.dbg_state, 0);
    chk("rst_idx", bif.dbg_clr_idx, 0);
    chk("rst_rd_valid", bif.rd_valid, 0);
    chk("rst_hit", bif.hit, 0);
    chk("rst_target", bif.Target, 0);
    chk("rst_wr_drop", bif.wr_drop, 0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    set_idle();
    bif2.bank_sel = '0; bif2.bank_switch = 1'b0; bif2.wr_en = 1'b0; bif2.wr_bank = '0;
    bif2.wr_addr = '0; bif2.wr_data = '0; bif2.clr_req = 1'b0; bif2.rd_req = 1'b0; bif2.rd_addr = '0;
    Reset_n = 1'b1;
    model_reset();
    reset_now();

    // load and lookup
    step(1, 0, 5, 'h092, 0, 0, 0, 0, 0);
    read_step(5);
    chk("load_hit", bif.hit, 1);
    chk("load_target", bif.Target, 'h092);
    read_step(6);
    chk("miss_hit", bif.hit, 0);
    chk("miss_target", bif.Target, 0);
    idle_step();
    chk("rd_valid_drop", bif.rd_valid, 0);

    // bank switch: same-edge lookup still sees bank 0
    step(1, 2, 5, 'h019, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 5, 1, 2, 0);
    chk("switch_old_bank", bif.Target, 'h092);
    read_step(5);
    chk("switch_new_bank", bif.Target, 'h019);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0);

    // write-through bypass
    step(1, 0, 3, 'h12C, 1, 3, 0, 0, 0);
    chk("bypass_hit", bif.hit, 1);
    chk("bypass_target", bif.Target, 'h12C);

    // clear: length, dropped write, nothing left valid
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cnt = 0;
    for (int i = 0; i < 100 && bif.busy; i++) begin
      cnt++;
      if (i == 3) begin
        step(1, 1, 7, 'h3FF, 1, 5, 0, 0, 1);
        chk("clr_wr_drop", bif.wr_drop, 1);
        chk("clr_rd_valid", bif.rd_valid, 1);
        chk("clr_rd_hit", bif.hit, 0);
      end else idle_step();
    end
    chk("clr_len", cnt, DEPTH);
    check_all_invalid("post_clr_hit");

    // write+clear on the same idle edge: write dropped, clear entered
    step(1, 0, 9, 'h155, 0, 0, 0, 0, 1);
    chk("wr_clr_drop", bif.wr_drop, 1);
    chk("wr_clr_busy", bif.busy, 1);
    while (busy_cnt > 0) idle_step();

    // reset in the middle of a clear
    for (int a = 0; a < 8; a++) step(1, a % 4, a, 'h100 + a, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (10) idle_step();
    chk("mid_clr_idx", bif.dbg_clr_idx, 10);
    reset_now();
    check_all_invalid("post_rst_hit");

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int wa, ra;
      wa = $urandom_range(0, DEPTH - 1);
      ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, DEPTH - 1);
      step($urandom_range(0, 1), $urandom_range(0, 3), wa, $urandom_range(0, 1023),
           $urandom_range(0, 9) < 6, ra, $urandom_range(0, 9) == 0, $urandom_range(0, 3),
           $urandom_range(0, 199) == 0);
    end
    set_idle();

    // small instance: max index, wide data, 8-cycle clear
    @(negedge Clk);
    bif2.wr_en = 1'b1; bif2.wr_bank = 1'b1; bif2.wr_addr = 3'd7; bif2.wr_data = 16'hFFFF;
    bif2.bank_switch = 1'b1; bif2.bank_sel = 1'b1;
    @(negedge Clk);
    bif2.wr_en = 1'b0; bif2.bank_switch = 1'b0; bif2.rd_req = 1'b1; bif2.rd_addr = 3'd7;
    @(posedge Clk); #1;
    chk("p2_rd_valid", bif2.rd_valid, 1);
    chk("p2_hit", bif2.hit, 1);
    chk("p2_target", bif2.Target, 16'hFFFF);
    @(negedge Clk);
    bif2.rd_req = 1'b0; bif2.clr_req = 1'b1;
    @(negedge Clk);
    bif2.clr_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 50 && bif2.busy; i++) begin
      cnt++;
      @(negedge Clk);
    end
    chk("p2_clr_len", cnt, 8);
    bif2.rd_req = 1'b1;
    @(posedge Clk); #1;
    chk("p2_post_clr_hit", bif2.hit, 0);
    @(negedge Clk);
    bif2.rd_req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
